// File: rtl/if_id_skid_pkg.sv
// Shared definitions for the IF/ID skid pipeline register (package pipe_pkg).
package pipe_pkg;
    localparam int          PC_W_DEF   = 32;
    localparam int          IS_W_DEF   = 32;
    localparam logic [31:0] NOP_IS_DEF = 32'h0000_0013;
    localparam int          PERF_W     = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;
endpackage

// File: rtl/if_id_skid_slot.sv
// pipe_slot: one valid+PC+instruction register. Clear wins over load and
// returns the payload to the bubble encoding.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int              PC_W   = PC_W_DEF,
    parameter int              IS_W   = IS_W_DEF,
    parameter logic [IS_W-1:0] NOP_IS = IS_W'(NOP_IS_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [PC_W-1:0] d_pc,
    input  logic [IS_W-1:0] d_is,
    output logic            vld,
    output logic [PC_W-1:0] pc,
    output logic [IS_W-1:0] is_o
);
    logic            vld_q, vld_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IS_W-1:0] is_q, is_d;

    always_comb begin
        vld_d = vld_q;
        pc_d  = pc_q;
        is_d  = is_q;
        if (clear) begin
            vld_d = 1'b0;
            pc_d  = '0;
            is_d  = NOP_IS;
        end else if (load) begin
            vld_d = 1'b1;
            pc_d  = d_pc;
            is_d  = d_is;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= 1'b0;
            pc_q  <= '0;
            is_q  <= NOP_IS;
        end else begin
            vld_q <= vld_d;
            pc_q  <= pc_d;
            is_q  <= is_d;
        end
    end

    assign vld  = vld_q;
    assign pc   = pc_q;
    assign is_o = is_q;
endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional IF_ID_PERF_EN adds stall_cnt/flush_cnt performance counters.
module if_id_skid
    import pipe_pkg::*;
#(
    parameter int              PC_W   = PC_W_DEF,
    parameter int              IS_W   = IS_W_DEF,
    parameter logic [IS_W-1:0] NOP_IS = IS_W'(NOP_IS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [IS_W-1:0]   if_is,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   id_pc,
    output logic [IS_W-1:0]   id_is
`ifdef IF_ID_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);
    logic            main_vld, skid_vld;
    logic [PC_W-1:0] main_pc, skid_pc, main_d_pc;
    logic [IS_W-1:0] main_is, skid_is, main_d_is;
    logic            main_load, main_clr, main_from_skid, skid_load, skid_clr;
    logic            accept, consume, in_ready_q, in_ready_d;
    occ_e            occ, occ_d;

    // Occupancy is carried by the two slot valid bits; skid is only ever
    // filled while main is full.
    assign occ     = skid_vld ? TWO : (main_vld ? ONE : EMPTY);
    assign accept  = in_valid & in_ready_q;
    assign consume = main_vld & out_ready;

    always_comb begin
        occ_d          = occ;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            occ_d    = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (occ)
                EMPTY: if (accept) begin
                    main_load = 1'b1;
                    occ_d     = ONE;
                end
                ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (consume) begin
                        main_clr = 1'b1;
                        occ_d    = EMPTY;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        occ_d     = TWO;
                    end
                end
                TWO: if (consume) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                    occ_d          = ONE;
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                    occ_d    = EMPTY;
                end
            endcase
        end
        // Ready looks only at next occupancy, so out_ready never reaches in_ready combinationally.
        in_ready_d = (occ_d != TWO);
    end

    assign main_d_pc = main_from_skid ? skid_pc : if_pc;
    assign main_d_is = main_from_skid ? skid_is : if_is;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_ready_q <= 1'b1;
        else      in_ready_q <= in_ready_d;
    end

    pipe_slot #(.PC_W(PC_W), .IS_W(IS_W), .NOP_IS(NOP_IS)) u_main (
        .clk(clk), .rst(rst), .load(main_load), .clear(main_clr),
        .d_pc(main_d_pc), .d_is(main_d_is),
        .vld(main_vld), .pc(main_pc), .is_o(main_is)
    );

    pipe_slot #(.PC_W(PC_W), .IS_W(IS_W), .NOP_IS(NOP_IS)) u_skid (
        .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clr),
        .d_pc(if_pc), .d_is(if_is),
        .vld(skid_vld), .pc(skid_pc), .is_o(skid_is)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign id_pc     = main_pc;
    assign id_is     = main_is;

`ifdef IF_ID_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + PERF_W'(in_valid & ~in_ready_q);
        flush_cnt_d = flush_cnt_q + PERF_W'(flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_skid.sv
// Randomized + directed bench for if_id_skid against a queue-based FIFO model.
module tb_if_id_skid;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] if_pc, if_is, id_pc, id_is;
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] q[$];
    int unsigned m_stall, m_flush;

    always #5 clk = ~clk;

    if_id_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .if_pc(if_pc), .if_is(if_is),
        .out_valid(out_valid), .out_ready(out_ready),
        .id_pc(id_pc), .id_is(id_is)
`ifdef IF_ID_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        logic [63:0] head;
        head = (q.size() > 0) ? q[0] : {32'h0, NOP};
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, ".id_pc"}, 64'(id_pc), 64'(head[63:32]));
        chk({tag, ".id_is"}, 64'(id_is), 64'(head[31:0]));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
`ifdef IF_ID_PERF_EN
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    // One clock: drive inputs, advance the model by the FIFO rules, check after the edge.
    task automatic step(input string tag, input logic iv, input logic [31:0] pc,
                        input logic [31:0] is_v, input logic ordy, input logic fl);
        bit acc, con;
        in_valid  = iv;
        if_pc     = pc;
        if_is     = is_v;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (q.size() < 2);
        con = ordy && (q.size() > 0);
        if (iv && q.size() >= 2) m_stall++;
        if (fl) m_flush++;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back({pc, is_v});
        end
        #1;
        check_outs(tag);
    endtask

    initial begin
        bit          pend;
        logic [31:0] ppc, pis;
        bit          rdy, ord, fl;

        rst = 1'b0; flush = 0; in_valid = 0; out_ready = 0; if_pc = 0; if_is = 0;
        m_stall = 0; m_flush = 0;
        #12;
        check_outs("reset");
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 1, 0);

        // streaming
        step("stream0", 1, 32'h0, 32'h0050_0093, 1, 0);
        step("stream1", 1, 32'h4, 32'h0010_8113, 1, 0);
        step("stream2", 1, 32'h8, 32'h0021_01B3, 1, 0);
        step("stream_drain", 0, 0, 0, 1, 0);
        step("stream_drain", 0, 0, 0, 1, 0);

        // stall fill, then drain in order
        step("fill0", 1, 32'h10, 32'hAAAA_0001, 0, 0);
        step("fill1", 1, 32'h14, 32'hAAAA_0002, 0, 0);
        chk("fill_in_ready_low", 64'(in_ready), 64'd0);
        step("hold18", 1, 32'h18, 32'hAAAA_0003, 0, 0);
        step("hold18", 1, 32'h18, 32'hAAAA_0003, 0, 0);
        chk("hold_id_pc", 64'(id_pc), 64'h10);
        step("drain0", 1, 32'h18, 32'hAAAA_0003, 1, 0);
        chk("drain0_pc", 64'(id_pc), 64'h14);
        step("drain1", 1, 32'h18, 32'hAAAA_0003, 1, 0);
        chk("drain1_pc", 64'(id_pc), 64'h18);
        step("drain2", 0, 0, 0, 1, 0);
        chk("drain2_empty", 64'(out_valid), 64'd0);

        // flush in TWO discards incoming 0x20
        step("f_fill0", 1, 32'h30, 32'h1111_0001, 0, 0);
        step("f_fill1", 1, 32'h34, 32'h1111_0002, 0, 0);
        step("flush_two", 1, 32'h20, 32'h2222_0000, 0, 1);
        chk("flush_nop", 64'(id_is), 64'(NOP));
        step("post_flush", 0, 0, 0, 1, 0);
        chk("post_flush_vld", 64'(out_valid), 64'd0);

        // accept+consume in ONE for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step("thru", 1, 32'h40 + 32'(i * 4), 32'h3300_0000 + 32'(i), 1, 0);
            chk("thru_pc", 64'(id_pc), 64'(32'h40 + 32'(i * 4)));
            chk("thru_rdy", 64'(in_ready), 64'd1);
        end
        step("thru_drain", 0, 0, 0, 1, 0);

        // stall 7 cycles in TWO, then 2 flushes
        step("p_fill0", 1, 32'h50, 32'h4400_0001, 0, 0);
        step("p_fill1", 1, 32'h54, 32'h4400_0002, 0, 0);
        for (int i = 0; i < 7; i++) step("p_stall", 1, 32'h58, 32'h4400_0003, 0, 0);
        step("p_flush", 0, 0, 0, 0, 1);
        step("p_flush", 0, 0, 0, 0, 1);

        // reset mid-operation drops both entries at once
        step("r_fill0", 1, 32'h60, 32'h5500_0001, 0, 0);
        step("r_fill1", 1, 32'h64, 32'h5500_0002, 0, 0);
        #2 rst = 1'b0;
        #1;
        q.delete(); m_stall = 0; m_flush = 0;
        check_outs("midreset");
        @(negedge clk); rst = 1'b1;
        step("after_reset", 0, 0, 0, 1, 0);

        // randomized: fetch holds an item until accepted or flushed
        pend = 0; ppc = 32'h1000; pis = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend = 1;
                ppc  = ppc + 4;
                pis  = $urandom;
            end
            ord = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            rdy = (q.size() < 2);
            step("rand", pend, ppc, pis, ord, fl);
            if (pend && (rdy || fl)) pend = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_skid.md
Name: if_id_skid

Overview:
Parametrised successor to the plain IF/ID latch. Pipeline register between fetch and decode with a valid/ready handshake and a 2-entry skid buffer, so decode can stall without a combinational ready path back to fetch. Also provides a synchronous flush that kills in-flight instructions on branch/jump redirect. Decode sees a bubble instruction (NOP) whenever no valid instruction is held.

Parameters:
PC_W, 32, program-counter width in bits
IS_W, 32, instruction width in bits
NOP_IS, 32'h00000013, bubble encoding driven on id_is when empty or flushed (RV32I addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
flush  in  1  kill all held and incoming instructions this cycle
in_valid  in  1  fetch presents if_pc/if_is
in_ready  out  1  block can accept (registered)
if_pc  in  PC_W  fetched PC
if_is  in  IS_W  fetched instruction
out_valid  out  1  id_pc/id_is hold a live instruction
out_ready  in  1  decode consumes this cycle
id_pc  out  PC_W  PC to decode
id_is  out  IS_W  instruction to decode

Behaviour:
- Reset (rst=0, async): out_valid=0, id_pc=0, id_is=NOP_IS, in_ready=1, skid empty. Deassertion takes effect on the next rising edge.
- Handshake:
  - accept = in_valid & in_ready
  - consume = out_valid & out_ready
  - in_ready is a flop output only; never a combinational function of out_ready.
- States, by occupancy:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - TWO: main full, skid full.
- EMPTY:
  - accept loads main, go to ONE.
  - Latency: in at edge N, visible on id_* after edge N (one cycle).
- ONE:
  - accept & consume: main takes new, stay ONE.
  - consume only: go EMPTY.
  - accept only: new goes to skid, go TWO, in_ready drops to 0.
  - neither: hold.
- TWO:
  - in_ready=0.
  - consume: skid moves to main, go ONE, in_ready returns to 1.
  - otherwise hold.
- Order: strict FIFO. Skid contents are always younger than main.
- Flush:
  - Highest priority; synchronous.
  - Next state EMPTY. Any same-cycle accept is discarded.
  - id_is=NOP_IS, id_pc=0, in_ready=1.
  - The consume in the flush cycle still counts for decode; the next cycle is a bubble.
- When out_valid=0, id_is is always NOP_IS, so downstream may ignore out_valid safely.
- The in_valid=1 / in_ready=0 case is legal. Fetch must hold if_pc/if_is stable until accepted.
- Reset mid-operation: both entries are dropped immediately, outputs return to reset values.
- No arithmetic; pure storage. Widths pass through unchanged.

Optional Feature:
Macro IF_ID_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle with in_valid & ~in_ready.
  - flush_cnt increments each cycle with flush=1.
  - Both wrap from 32'hFFFFFFFF to 0 and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package (pipe_pkg):
  - default PC_W/IS_W
  - NOP_IS constant
  - occupancy state typedef (EMPTY/ONE/TWO)
  - perf counter width constant
- One natural sub-module: pipe_slot, a single valid+payload register with load/clear. Instantiate twice (main, skid). Top holds the FSM and muxing.

Test Plan:
- Reset then idle:
  - Stimulus: rst=0 mid-cycle, then release; in_valid=0.
  - Expected: out_valid=0, id_is=32'h00000013, id_pc=0, in_ready=1 at all times.
- Streaming:
  - Stimulus: out_ready=1; PCs 0x0,0x4,0x8 with is 0x00500093, 0x00108113, 0x002101B3 on consecutive cycles.
  - Expected: each appears on id_* exactly one cycle later; in_ready stays 1.
- Stall fill:
  - Stimulus: out_ready=0; send 0x10/0xAAAA0001 then 0x14/0xAAAA0002.
  - Expected: in_ready=0 after the second accept. 0x18 held by fetch is not taken.
  - Then: out_ready=1 yields 0x10, 0x14, 0x18 in order, with no loss or duplicate.
- Flush in TWO:
  - Stimulus: state TWO; assert flush with in_valid=1 carrying 0x20.
  - Expected: next cycle out_valid=0, id_is=NOP_IS, in_ready=1; 0x20 never appears.
- Simultaneous accept+consume in ONE:
  - Stimulus: in_valid=1, out_ready=1 for 5 cycles.
  - Expected: throughput 1/cycle; skid never used (in_ready constant 1).
- IF_ID_PERF_EN:
  - Stimulus: hold TWO with in_valid=1 for 7 cycles, then 2 flush cycles.
  - Expected: stall_cnt=7, flush_cnt=2.
